instruction_ram_loader: RTL and testbench
=========================================

# instruction_ram_loader

Parametrised, run-time loadable successor to the fixed instruction ROM. It holds the processor's program in a writable array and keeps the same combinational fetch port, so the CPU core is unchanged. It adds a byte-stream loader with a valid/ready handshake and busy/done status, so programs are downloaded without resynthesis. It sits between the instruction-address output of the core and an external byte source, such as a UART receiver.

## Interface
Parameters:
- DATA_WIDTH, 28: instruction width in bits.
- ADDR_WIDTH, 16: width of iAddress and iLoadAddr.
- DEPTH, 256: number of instruction words. Must be ≤ 2^ADDR_WIDTH.
- DEFAULT_INSTR, {DATA_WIDTH{1'b0}}: word returned for masked or out-of-range fetches. Also the power-up content of every location.

Ports:
- Clock, input, 1: single clock, rising edge.
- Reset, input, 1: synchronous, active-high.
- iAddress, input, ADDR_WIDTH: fetch address.
- oInstruction, output, DATA_WIDTH: fetched instruction (combinational).
- iLoadStart, input, 1: one-cycle request to begin a load.
- iLoadAddr, input, ADDR_WIDTH: first word address, sampled with iLoadStart.
- iLoadCount, input, ADDR_WIDTH: number of words to load, sampled with iLoadStart.
- iLoadAbort, input, 1: cancel the load in progress.
- iByte, input, 8: load data byte.
- iByteValid, input, 1: iByte is valid.
- oByteReady, output, 1: the loader accepts a byte this cycle.
- oLoading, output, 1: high while the FSM is in LOAD.
- oLoadDone, output, 1: one-cycle pulse when a load completes.

## Operation
- BYTES = ceil(DATA_WIDTH/8), which is 4 for the defaults.
- Fetch:
  - oInstruction = mem[iAddress] when iAddress < DEPTH and oLoading = 0.
  - Otherwise oInstruction = DEFAULT_INSTR.
- The FSM has three states: IDLE, LOAD, DONE.
- IDLE:
  - oByteReady = 0.
  - iLoadStart = 1 latches base = iLoadAddr mod DEPTH and remaining = iLoadCount, and clears the byte index.
  - Next state is LOAD if iLoadCount ≠ 0, else DONE.
- LOAD:
  - oByteReady = 1 and oLoading = 1.
  - A byte transfers when iByteValid & oByteReady. Bytes are little-endian: byte k fills bits [8k+7:8k] of the assembly register.
  - Bits beyond DATA_WIDTH in the last byte are discarded.
  - On the BYTES-th accepted byte, the full word (including that byte) is written to mem[addr]. Then:
    - addr increments, wrapping DEPTH-1 → 0;
    - remaining decrements;
    - the byte index clears.
  - When remaining reaches 0 on that write, next state is DONE.
  - iLoadStart is ignored in LOAD.
  - iLoadAbort = 1 returns to IDLE without a DONE pulse. The partially assembled word is discarded; words already written are kept. Abort takes priority over a byte transfer in the same cycle, so that byte is not written.
- DONE:
  - oLoadDone = 1 for exactly one cycle.
  - Next state is IDLE unconditionally.
- Reset:
  - FSM goes to IDLE. addr, remaining, byte index and the assembly register clear.
  - Memory contents are NOT altered by Reset.
- Power-up: every memory location initialises to DEFAULT_INSTR.

## Timing
- Fetch: zero latency, combinational from iAddress.
- Write: occurs on the clock edge that accepts the final byte of a word. The new value is visible on fetch from the next cycle, once the load has left LOAD.
- Load entry: iLoadStart at edge N puts the FSM in LOAD after edge N. oByteReady is high from cycle N+1.
- Throughput: one byte per cycle, so one word per BYTES cycles at full rate.
- Back-pressure: when iByteValid = 0, LOAD holds state and nothing changes.
- Completion: the edge accepting the last byte enters DONE. oLoadDone is high for the following cycle and oLoading is low in that cycle, so fetch is unmasked. IDLE follows.
- Zero-count load: iLoadStart with count 0 gives LOAD never entered and oLoadDone high in cycle N+1.
- Reset values: oInstruction follows the fetch rule with oLoading = 0; oByteReady = 0, oLoading = 0, oLoadDone = 0.
- Reset mid-load: next cycle in IDLE, no DONE pulse, memory keeps every word written before the reset edge.
- iLoadStart with Reset in the same cycle: Reset wins.

## Test plan
1. Power-up fetch: after Reset, iAddress = 0, 5, 255 and 256 → all return 28'h0000000 (DEFAULT_INSTR); oByteReady = 0.
2. Single-word load: iLoadStart with iLoadAddr = 3 and iLoadCount = 1, then bytes 0x44, 0x33, 0x22, 0x1F at full rate → oLoadDone pulses one cycle after the 4th byte. Fetch at 3 returns 28'hF223344 (top nibble of 0x1F dropped). Fetch returns DEFAULT_INSTR while oLoading = 1.
3. Wrap and back-pressure: load 2 words at base 255 with iByteValid toggling every other cycle → words land at 255 and 0. oLoadDone asserts only after the 8th accepted byte. Address 1 is untouched.
4. Abort: start a 2-word load at 10, send 6 bytes, assert iLoadAbort together with the 7th byte → IDLE next cycle, no oLoadDone. mem[10] holds word 1, mem[11] is unchanged.
5. Zero count and ignored restart: iLoadCount = 0 → oLoadDone in the next cycle with no writes. During a later load, pulse iLoadStart with a different iLoadAddr → ignored, and the original base is used.
6. Reset mid-load: Reset after 5 bytes of a 2-word load at 20 → oLoading = 0 next cycle. mem[20] holds the first word, and mem[21] still returns DEFAULT_INSTR.

Source files
------------

// File: rtl/instruction_ram_loader.sv
// Run-time loadable instruction memory: a combinational fetch port for the core plus a
// little-endian byte-stream loader with a valid/ready handshake and busy/done status.
module instruction_ram_loader #(
    parameter int                    DATA_WIDTH    = 28,
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    DEPTH         = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = {DATA_WIDTH{1'b0}}
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH-1:0] iLoadAddr,
    input  logic [ADDR_WIDTH-1:0] iLoadCount,
    input  logic                  iLoadAbort,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oLoading,
    output logic                  oLoadDone
);

    localparam int BYTES  = (DATA_WIDTH + 7) / 8;
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [MEM_AW-1:0]     r_addr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [DATA_WIDTH-1:0] r_asm;

    // NOTE: the program array deliberately has no reset branch; a declaration
    // initialiser gives the power-up contents, and Reset must leave a loaded program intact.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: DEFAULT_INSTR};

    state_t                w_state_next;
    logic [MEM_AW-1:0]     w_addr_next;
    logic [ADDR_WIDTH-1:0] w_remaining_next;
    logic [IDX_W-1:0]      w_byte_idx_next;
    logic [DATA_WIDTH-1:0] w_asm_next;
    logic [DATA_WIDTH-1:0] w_asm_fill;
    logic [MEM_AW-1:0]     w_base;
    logic                  w_last_byte;
    logic                  w_mem_we;
    logic                  w_in_range;
    logic                  w_byte_ready;
    logic                  w_loading;
    logic                  w_load_done;

    assign w_base      = MEM_AW'(32'(iLoadAddr) % 32'(DEPTH));
    assign w_last_byte = (r_byte_idx == IDX_W'(BYTES - 1));

    // Assembly register with the incoming byte merged in; bits past DATA_WIDTH are dropped.
    always_comb begin
        w_asm_fill = r_asm;
        for (int k = 0; k < BYTES; k++) begin
            if (r_byte_idx == IDX_W'(k)) begin
                for (int j = 0; j < 8; j++) begin
                    if (8 * k + j < DATA_WIDTH) begin
                        w_asm_fill[8 * k + j] = iByte[j];
                    end
                end
            end
        end
    end

    // NOTE: combinational process assigns every output a default first, so no latches can form.
    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_remaining_next = r_remaining;
        w_byte_idx_next  = r_byte_idx;
        w_asm_next       = r_asm;
        w_mem_we         = 1'b0;
        w_byte_ready     = 1'b0;
        w_loading        = 1'b0;
        w_load_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (iLoadStart) begin
                    w_addr_next      = w_base;
                    w_remaining_next = iLoadCount;
                    w_byte_idx_next  = '0;
                    w_asm_next       = '0;
                    w_state_next     = (iLoadCount != '0) ? S_LOAD : S_DONE;
                end
            end

            S_LOAD: begin
                w_byte_ready = 1'b1;
                w_loading    = 1'b1;
                // Abort outranks a byte arriving in the same cycle.
                if (iLoadAbort) begin
                    w_byte_idx_next = '0;
                    w_asm_next      = '0;
                    w_state_next    = S_IDLE;
                end else if (iByteValid) begin
                    if (w_last_byte) begin
                        w_mem_we         = 1'b1;
                        w_addr_next      = (r_addr == MEM_AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
                        w_remaining_next = r_remaining - 1'b1;
                        w_byte_idx_next  = '0;
                        w_asm_next       = '0;
                        if (r_remaining == ADDR_WIDTH'(1)) begin
                            w_state_next = S_DONE;
                        end
                    end else begin
                        w_byte_idx_next = r_byte_idx + 1'b1;
                        w_asm_next      = w_asm_fill;
                    end
                end
            end

            S_DONE: begin
                w_load_done  = 1'b1;
                w_state_next = S_IDLE;
            end

            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_remaining <= w_remaining_next;
            r_byte_idx  <= w_byte_idx_next;
            r_asm       <= w_asm_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_mem_we && !Reset) begin
            r_mem[r_addr] <= w_asm_fill;
        end
    end

    // Fetch is masked while a download is rewriting the array.
    assign w_in_range   = (32'(iAddress) < 32'(DEPTH));
    assign oInstruction = (w_in_range && !w_loading) ? r_mem[iAddress[MEM_AW-1:0]] : DEFAULT_INSTR;
    assign oByteReady   = w_byte_ready;
    assign oLoading     = w_loading;
    assign oLoadDone    = w_load_done;

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Directed bench for instruction_ram_loader: table-driven fetch checks plus hand-written
// load, wrap, back-pressure, abort, zero-count, ignored-restart and reset sequences.
module tb_instruction_ram_loader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] iAddress;
    logic [27:0] oInstruction;
    logic        iLoadStart;
    logic [15:0] iLoadAddr;
    logic [15:0] iLoadCount;
    logic        iLoadAbort;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oLoading;
    logic        oLoadDone;

    int checks   = 0;
    int failures = 0;

    instruction_ram_loader dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iAddress     (iAddress),
        .oInstruction (oInstruction),
        .iLoadStart   (iLoadStart),
        .iLoadAddr    (iLoadAddr),
        .iLoadCount   (iLoadCount),
        .iLoadAbort   (iLoadAbort),
        .iByte        (iByte),
        .iByteValid   (iByteValid),
        .oByteReady   (oByteReady),
        .oLoading     (oLoading),
        .oLoadDone    (oLoadDone)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [27:0] exp;
    } fetch_vec_t;

    fetch_vec_t powerup_tab [4];
    fetch_vec_t final_tab   [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input string name, input logic [15:0] addr, input logic [27:0] exp);
        iAddress = addr;
        #1;
        check(name, {4'h0, oInstruction}, {4'h0, exp});
    endtask

    task automatic start_load(input logic [15:0] addr, input logic [15:0] count);
        iLoadStart = 1'b1;
        iLoadAddr  = addr;
        iLoadCount = count;
        step();
        iLoadStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        iByte      = b;
        iByteValid = 1'b1;
        step();
        iByteValid = 1'b0;
    endtask

    initial begin
        powerup_tab[0] = '{"pwr_a0",   16'd0,   28'h0000000};
        powerup_tab[1] = '{"pwr_a5",   16'd5,   28'h0000000};
        powerup_tab[2] = '{"pwr_a255", 16'd255, 28'h0000000};
        powerup_tab[3] = '{"pwr_a256", 16'd256, 28'h0000000};

        final_tab[0]  = '{"fin_a3",     16'd3,     28'hF223344};
        final_tab[1]  = '{"fin_a255",   16'd255,   28'hA0B0C0D};
        final_tab[2]  = '{"fin_a0",     16'd0,     28'h4030201};
        final_tab[3]  = '{"fin_a1",     16'd1,     28'h0000000};
        final_tab[4]  = '{"fin_a10",    16'd10,    28'h4332211};
        final_tab[5]  = '{"fin_a11",    16'd11,    28'h0000000};
        final_tab[6]  = '{"fin_a50",    16'd50,    28'h7452301};
        final_tab[7]  = '{"fin_a60",    16'd60,    28'h0000000};
        final_tab[8]  = '{"fin_a20",    16'd20,    28'h0DEBC9A};
        final_tab[9]  = '{"fin_a21",    16'd21,    28'h0000000};
        final_tab[10] = '{"fin_a256",   16'd256,   28'h0000000};

        Reset      = 1'b1;
        iAddress   = '0;
        iLoadStart = 1'b0;
        iLoadAddr  = '0;
        iLoadCount = '0;
        iLoadAbort = 1'b0;
        iByte      = '0;
        iByteValid = 1'b0;
        step();
        step();
        Reset = 1'b0;

        // 1. Power-up / reset state
        check("rst_ready",   {31'd0, oByteReady}, 32'd0);
        check("rst_loading", {31'd0, oLoading},   32'd0);
        check("rst_done",    {31'd0, oLoadDone},  32'd0);
        for (int i = 0; i < 4; i++) begin
            fetch(powerup_tab[i].name, powerup_tab[i].addr, powerup_tab[i].exp);
        end

        // 2. Single-word load at 3
        step();
        start_load(16'd3, 16'd1);
        check("t2_ready",   {31'd0, oByteReady}, 32'd1);
        check("t2_loading", {31'd0, oLoading},   32'd1);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        check("t2_no_early_done", {31'd0, oLoadDone}, 32'd0);
        fetch("t2_masked", 16'd3, 28'h0000000);
        send_byte(8'h1F);
        check("t2_done",       {31'd0, oLoadDone}, 32'd1);
        check("t2_done_nload", {31'd0, oLoading},  32'd0);
        fetch("t2_word", 16'd3, 28'hF223344);
        step();
        check("t2_done_once", {31'd0, oLoadDone}, 32'd0);
        check("t2_idle_rdy",  {31'd0, oByteReady}, 32'd0);

        // 3. Wrap at 255 with valid toggling every other cycle
        begin
            logic [7:0] bytes3 [8];
            int done_seen;
            bytes3 = '{8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04};
            done_seen = 0;
            start_load(16'd255, 16'd2);
            for (int i = 0; i < 8; i++) begin
                send_byte(bytes3[i]);
                if (i < 7) begin
                    if (oLoadDone) done_seen++;
                    step();
                    if (oLoadDone) done_seen++;
                end
            end
            check("t3_early_done", done_seen, 32'd0);
            check("t3_done", {31'd0, oLoadDone}, 32'd1);
            fetch("t3_a255", 16'd255, 28'hA0B0C0D);
            fetch("t3_a0",   16'd0,   28'h4030201);
            fetch("t3_a1",   16'd1,   28'h0000000);
            step();
        end

        // 4. Abort together with the 7th byte of a 2-word load at 10
        start_load(16'd10, 16'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        iLoadAbort = 1'b1;
        send_byte(8'h77);
        iLoadAbort = 1'b0;
        check("t4_loading", {31'd0, oLoading},  32'd0);
        check("t4_no_done", {31'd0, oLoadDone}, 32'd0);
        fetch("t4_a10", 16'd10, 28'h4332211);
        fetch("t4_a11", 16'd11, 28'h0000000);
        step();
        check("t4_no_done_later", {31'd0, oLoadDone}, 32'd0);

        // 5a. Zero-count load
        start_load(16'd40, 16'd0);
        check("t5_zero_done", {31'd0, oLoadDone}, 32'd1);
        check("t5_zero_nld",  {31'd0, oLoading},  32'd0);
        step();
        check("t5_zero_once", {31'd0, oLoadDone}, 32'd0);

        // 5b. Restart during a load is ignored
        start_load(16'd50, 16'd1);
        send_byte(8'h01);
        send_byte(8'h23);
        iLoadStart = 1'b1;
        iLoadAddr  = 16'd60;
        iLoadCount = 16'd3;
        step();
        iLoadStart = 1'b0;
        check("t5_still_loading", {31'd0, oLoading}, 32'd1);
        send_byte(8'h45);
        send_byte(8'h67);
        check("t5_done", {31'd0, oLoadDone}, 32'd1);
        fetch("t5_a50", 16'd50, 28'h7452301);
        fetch("t5_a60", 16'd60, 28'h0000000);
        step();

        // 6. Reset after 5 bytes of a 2-word load at 20
        start_load(16'd20, 16'd2);
        send_byte(8'h9A);
        send_byte(8'hBC);
        send_byte(8'hDE);
        send_byte(8'hF0);
        send_byte(8'h12);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t6_loading", {31'd0, oLoading},   32'd0);
        check("t6_no_done", {31'd0, oLoadDone},  32'd0);
        check("t6_ready",   {31'd0, oByteReady}, 32'd0);
        step();
        check("t6_no_done_later", {31'd0, oLoadDone}, 32'd0);

        // Final memory image across all sequences, including words that survived Reset
        for (int i = 0; i < 11; i++) begin
            fetch(final_tab[i].name, final_tab[i].addr, final_tab[i].exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
